// File: rtl/lfo_pkg.sv
// Shared types for the LFO modulation source: waveform select, phase direction
// and the onset/run sequencing states.
package lfo_pkg;

  typedef enum logic [1:0] {
    TRI_UNI = 2'd0,
    TRI_BI  = 2'd1,
    SAW     = 2'd2,
    SQUARE  = 2'd3
  } lfo_mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } lfo_dir_t;

  typedef enum logic {
    ST_DELAY = 1'b0,
    ST_RUN   = 1'b1
  } lfo_state_t;

endpackage

// File: rtl/lfo_prescaler.sv
// Rate prescaler: counts 0..speed and flags a step event on the compare cycle.
// The first count begins one clock after enable is sampled high.
module lfo_prescaler #(
  parameter int SPEED_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               clear,
  input  logic [SPEED_W-1:0] speed,
  output logic               step
);

  logic               run_q;
  logic [SPEED_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (!enable) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      run_q <= 1'b1;
      if (clear) begin
        cnt_q <= '0;
      end else if (run_q) begin
        // A speed lowered below the count wraps through the full range.
        cnt_q <= (cnt_q == speed) ? '0 : cnt_q + 1'b1;
      end
    end
  end

  assign step = run_q && enable && !clear && (cnt_q == speed);

endmodule

// File: rtl/lfo_mod.sv
// Low-frequency modulation source: four depth-scaled waveforms stepped by the
// prescaler, with an onset delay counted in step events after each enable.
module lfo_mod
  import lfo_pkg::*;
#(
  parameter int DEPTH_W = 4,
  parameter int SPEED_W = 8,
  parameter int DELAY_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [1:0]                mode,
  input  logic [DEPTH_W-1:0]        depth,
  input  logic [SPEED_W-1:0]        speed,
  input  logic [DELAY_W-1:0]        delay,
  output logic signed [DEPTH_W:0]   lfo_o,
  output logic                      tick_o
);

  localparam int PW = DEPTH_W + 1;
  localparam logic signed [PW-1:0] ZERO = '0;
  localparam logic signed [PW-1:0] ONE  = {{(PW-1){1'b0}}, 1'b1};

  lfo_state_t               state_q, state_d;
  lfo_dir_t                 dir_q, dir_d, wave_dir;
  lfo_mode_t                mode_q, mode_d, mode_in;
  logic signed [PW-1:0]     phase_q, phase_d, wave_phase;
  logic signed [PW-1:0]     d_s;
  logic [DELAY_W-1:0]       dly_q, dly_d, dly_eff;
  logic                     dly_loaded_q, dly_loaded_d;
  logic                     tick_q, tick_d;
  logic                     mode_chg;
  logic                     step;

  assign mode_in  = lfo_mode_t'(mode);
  assign mode_chg = enable && (mode_in != mode_q);
  assign d_s      = $signed({1'b0, depth});
  assign dly_eff  = dly_loaded_q ? dly_q : delay;

  lfo_prescaler #(.SPEED_W(SPEED_W)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .clear  (mode_chg),
    .speed  (speed),
    .step   (step)
  );

  // Candidate next phase for one waveform step; applied only on a run step.
  always_comb begin
    wave_phase = phase_q;
    wave_dir   = dir_q;
    if (depth == '0) begin
      wave_phase = ZERO;
      wave_dir   = DIR_UP;
    end else if (phase_q > d_s || phase_q < -d_s) begin
      // Depth shrank under the current phase: clamp, keep sign, head to zero.
      if (phase_q > ZERO) begin
        wave_phase = d_s;
        wave_dir   = DIR_DOWN;
      end else begin
        wave_phase = -d_s;
        wave_dir   = DIR_UP;
      end
    end else begin
      case (mode_q)
        TRI_UNI, TRI_BI: begin
          if (dir_q == DIR_UP) begin
            if (phase_q >= d_s) begin
              wave_phase = phase_q - ONE;
              wave_dir   = DIR_DOWN;
            end else begin
              wave_phase = phase_q + ONE;
            end
          end else begin
            if (phase_q <= ((mode_q == TRI_UNI) ? ZERO : -d_s)) begin
              wave_phase = phase_q + ONE;
              wave_dir   = DIR_UP;
            end else begin
              wave_phase = phase_q - ONE;
            end
          end
        end
        SAW:     wave_phase = (phase_q >= d_s) ? ZERO : phase_q + ONE;
        default: wave_phase = (phase_q > ZERO) ? -d_s : d_s;
      endcase
    end
  end

  // NOTE: every variable assigned here gets its hold value first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    mode_d       = mode_q;
    phase_d      = phase_q;
    dly_d        = dly_q;
    dly_loaded_d = dly_loaded_q;
    tick_d       = 1'b0;
    if (!enable) begin
      state_d      = ST_DELAY;
      dir_d        = DIR_UP;
      mode_d       = mode_in;
      phase_d      = ZERO;
      dly_loaded_d = 1'b0;
    end else if (mode_chg) begin
      mode_d  = mode_in;
      phase_d = ZERO;
      dir_d   = DIR_UP;
    end else if (step) begin
      tick_d = 1'b1;
      if (state_q == ST_RUN || dly_eff == '0) begin
        state_d = ST_RUN;
        phase_d = wave_phase;
        dir_d   = wave_dir;
      end else begin
        dly_d        = dly_eff - 1'b1;
        dly_loaded_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_DELAY;
      dir_q        <= DIR_UP;
      mode_q       <= TRI_UNI;
      phase_q      <= ZERO;
      dly_q        <= '0;
      dly_loaded_q <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      mode_q       <= mode_d;
      phase_q      <= phase_d;
      dly_q        <= dly_d;
      dly_loaded_q <= dly_loaded_d;
      tick_q       <= tick_d;
    end
  end

  assign lfo_o  = phase_q;
  assign tick_o = tick_q;

endmodule

// File: tb/tb_lfo_mod.sv
// Self-checking bench for lfo_mod: directed scenarios plus randomized segments
// compared against a closed-form waveform model.
module tb_lfo_mod;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [1:0]        mode;
  logic [3:0]        depth;
  logic [7:0]        speed;
  logic [7:0]        delay;
  logic signed [4:0] lfo_o;
  logic              tick_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model state
  bit m_active;
  int m_t, m_n, m_dsteps, m_mode;
  int exp_lfo, exp_tick;

  lfo_mod dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .mode   (mode),
    .depth  (depth),
    .speed  (speed),
    .delay  (delay),
    .lfo_o  (lfo_o),
    .tick_o (tick_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Waveform value at modulation step n (n=0 is the rest value before any step).
  function automatic int wave(int md, int d, int n);
    int k;
    if (n == 0 || d == 0) return 0;
    case (md)
      0: begin
        k = n % (2 * d);
        return (k <= d) ? k : 2 * d - k;
      end
      1: begin
        k = n % (4 * d);
        if (k <= d) return k;
        if (k <= 3 * d) return 2 * d - k;
        return k - 4 * d;
      end
      2: return n % (d + 1);
      default: return (n % 2 == 1) ? d : -d;
    endcase
  endfunction

  // Evaluated at each rising edge with the inputs sampled there.
  task automatic model_update();
    exp_tick = 0;
    exp_lfo  = 0;
    if (!rst_n) begin
      m_active = 0;
      m_mode   = 0;
    end else if (!enable) begin
      m_active = 0;
      m_mode   = int'(mode);
    end else if (!m_active) begin
      m_active = 1;
      m_mode   = int'(mode);
      m_t = 0; m_n = 0; m_dsteps = 0;
    end else if (int'(mode) != m_mode) begin
      m_mode = int'(mode);
      m_t = 0; m_n = 0;
    end else begin
      m_t++;
      if (m_t % (int'(speed) + 1) == 0) begin
        exp_tick = 1;
        if (m_dsteps < int'(delay)) m_dsteps++;
        else m_n++;
      end
      exp_lfo = wave(m_mode, int'(depth), m_n);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_update();
    #1;
    check({tag, ".lfo"}, int'(lfo_o), exp_lfo);
    check({tag, ".tick"}, int'(tick_o), exp_tick);
  endtask

  task automatic cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  // Explicit expectation without the model (model resynchronises on disable).
  task automatic expect_step(input string tag, input int lfo_e, input int tick_e);
    @(posedge clk);
    #1;
    check({tag, ".lfo"}, int'(lfo_o), lfo_e);
    check({tag, ".tick"}, int'(tick_o), tick_e);
  endtask

  task automatic setup(input int md, input int d, input int sp, input int dl);
    enable = 1'b0;
    mode   = 2'(md);
    depth  = 4'(d);
    speed  = 8'(sp);
    delay  = 8'(dl);
    cycles("clear", 2);
    enable = 1'b1;
  endtask

  initial begin
    int seq_bi[12];
    int nd;
    m_active = 0; m_t = 0; m_n = 0; m_dsteps = 0; m_mode = 0;
    rst_n = 1'b0; enable = 1'b0; mode = 2'd0; depth = 4'd0; speed = 8'd0; delay = 8'd0;
    #1;
    check("reset.lfo", int'(lfo_o), 0);
    check("reset.tick", int'(tick_o), 0);
    cycles("reset", 3);
    #2 rst_n = 1'b1;

    // TRI_UNI depth 3 speed 1: 1,2,3,2,1,0,1 every two clocks
    setup(0, 3, 1, 0);
    cycles("tri_uni", 16);

    // TRI_BI depth 2 speed 0 delay 3: explicit sequence
    setup(1, 2, 0, 3);
    seq_bi = '{0, 0, 0, 0, 1, 2, 1, 0, -1, -2, -1, 0};
    for (int i = 0; i < 12; i++) expect_step("tri_bi_dly", seq_bi[i], (i == 0) ? 0 : 1);
    enable = 1'b0;
    cycle("tri_bi_off");

    // SAW and SQUARE
    setup(2, 4, 0, 0);
    cycles("saw", 12);
    setup(3, 5, 2, 1);
    cycles("square", 15);

    // Depth 7 -> 2 while phase is 6
    setup(0, 7, 0, 0);
    cycles("depth7", 7);
    depth = 4'd2;
    expect_step("depth_red", 2, 1);
    expect_step("depth_red", 1, 1);
    expect_step("depth_red", 0, 1);
    expect_step("depth_red", 1, 1);
    expect_step("depth_red", 2, 1);
    expect_step("depth_red", 1, 1);
    enable = 1'b0;
    cycle("depth_off");

    // Mode change mid-run, delay not re-armed; depth 0 in every mode
    setup(1, 6, 1, 2);
    cycles("pre_mode", 13);
    mode = 2'd2;
    cycles("mode_chg", 12);
    for (int md = 0; md < 4; md++) begin
      setup(md, 0, 0, 0);
      cycles("depth0", 6);
    end

    // Asynchronous reset mid-run, then enable drop, with delay re-applied
    setup(2, 4, 1, 2);
    cycles("pre_rst", 13);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst.lfo", int'(lfo_o), 0);
    check("async_rst.tick", int'(tick_o), 0);
    cycles("in_rst", 2);
    #2 rst_n = 1'b1;
    cycles("post_rst", 16);
    enable = 1'b0;
    cycles("en_drop", 2);
    enable = 1'b1;
    cycles("re_en", 14);

    // Randomized segments
    for (int s = 0; s < 40; s++) begin
      setup($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3));
      nd = $urandom_range(20, 60);
      for (int c = 0; c < nd; c++) begin
        cycle("rand");
        if ($urandom_range(0, 99) < 3) mode = mode + 2'($urandom_range(1, 3));
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
